// File: rtl/spi_slave_gen.sv
// spi_slave_gen: parametrised SPI slave bridge (word-wide parallel side).
// All four SPI modes are selected at runtime through cpol/cpha, latched per frame.
// sclk, cs_n and mosi are synchronised into clk, so sclk may be asynchronous,
// provided f_clk >= 6 * f_sclk.
// Optional feature macro: SPI_FRAME_ERR_EN adds the frame_err output, which
// flags a frame that ended in the middle of a word.
//
// Handshake: tx_ack is a one-clk strobe meaning "data_out has just been copied
// into the TX shifter". Upstream may present the next word after it and must
// hold that word stable until the next tx_ack. word_sync is a one-clk strobe
// meaning "data_in holds a newly completed word". Neither strobe can be
// back-pressured: the SPI master owns the timing.
module spi_slave_gen #(
   parameter int WORD_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   input  logic              cpol,
   input  logic              cpha,
   output logic              word_sync,
   output logic [WORD_W-1:0] data_in,
   input  logic [WORD_W-1:0] data_out,
   output logic              tx_ack,
   output logic              busy
`ifdef SPI_FRAME_ERR_EN
   ,
   output logic              frame_err
`endif
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   // synchroniser chains; vld_ff marks which stages hold a real post-reset sample
   logic [SYNC_STAGES-1:0] sclk_ff;
   logic [SYNC_STAGES-1:0] cs_ff;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic [SYNC_STAGES-1:0] vld_ff;

   logic sclk_s;
   logic cs_s;
   logic rx_bit;

   // edge detection and frame qualification
   logic sclk_q;
   logic cs_q;
   logic armed;
   logic cs_eff;
   logic cs_fall;
   logic cs_rise;
   logic in_frame;
   logic sclk_rise;
   logic sclk_fall;
   logic lead_ev;
   logic trail_ev;
   logic sample_ev;
   logic shift_ev;

   // per-frame mode and datapath
   logic              mode_cpol;
   logic              mode_cpha;
   logic              wb;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] rx_sh;
   logic [WORD_W-1:0] rx_next;
   logic [WORD_W-1:0] tx_sh;
   logic [WORD_W-1:0] tx_shifted;
   logic              tx_out;

   // bring the SPI pins into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_ff <= '1;
         cs_ff   <= '1;
         mosi_ff <= '0;
         vld_ff  <= '0;
      end else begin
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
         cs_ff   <= {cs_ff[SYNC_STAGES-2:0], cs_n};
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
         vld_ff  <= {vld_ff[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sclk_s = sclk_ff[SYNC_STAGES-1];
   assign cs_s   = cs_ff[SYNC_STAGES-1];
   assign rx_bit = mosi_ff[SYNC_STAGES-1];

   // A frame cut by reset must not resume: select only counts once cs_n has
   // really been seen high after reset, so the next true falling edge is needed.
   assign cs_eff    = ~armed | cs_s;
   assign cs_fall   = cs_q & ~cs_eff;
   assign cs_rise   = ~cs_q & cs_eff;
   assign in_frame  = ~cs_eff & ~cs_q;
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign lead_ev   = mode_cpol ? sclk_fall : sclk_rise;
   assign trail_ev  = mode_cpol ? sclk_rise : sclk_fall;
   assign sample_ev = in_frame & (mode_cpha ? trail_ev : lead_ev);
   assign shift_ev  = in_frame & (mode_cpha ? lead_ev : trail_ev);
   assign busy      = ~cs_eff;

   // delayed copies for edge detection plus the post-reset arming flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 1'b1;
         cs_q   <= 1'b1;
         armed  <= 1'b0;
      end else begin
         sclk_q <= sclk_s;
         cs_q   <= cs_eff;
         armed  <= armed | (vld_ff[SYNC_STAGES-1] & cs_s);
      end
   end

   // next RX word and shifted TX word in the configured bit order
   always_comb begin
      rx_next    = rx_sh;
      tx_shifted = tx_sh;
      tx_out     = 1'b0;
      if (MSB_FIRST) begin
         rx_next    = {rx_sh[WORD_W-2:0], rx_bit};
         tx_shifted = {tx_sh[WORD_W-2:0], 1'b0};
         tx_out     = tx_sh[WORD_W-1];
      end else begin
         rx_next    = {rx_bit, rx_sh[WORD_W-1:1]};
         tx_shifted = {1'b0, tx_sh[WORD_W-1:1]};
         tx_out     = tx_sh[0];
      end
   end

   // frame control, bit counter, shifters and output strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_cpol <= 1'b0;
         mode_cpha <= 1'b0;
         wb        <= 1'b1;
         bit_cnt   <= '0;
         rx_sh     <= '0;
         tx_sh     <= '0;
         data_in   <= '0;
         word_sync <= 1'b0;
         tx_ack    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         word_sync <= 1'b0;
         tx_ack    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         if (cs_eff) begin
            // idle (and the cs_n rise cycle, which overrides any sclk edge):
            // keep the next word preloaded and drop any partial word
            tx_sh   <= data_out;
            bit_cnt <= '0;
            wb      <= 1'b1;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= cs_rise & (bit_cnt != '0);
`endif
         end else if (cs_fall) begin
            mode_cpol <= cpol;
            mode_cpha <= cpha;
            wb        <= cpha;
            // with cpha=0 the preloaded word goes out as-is, so it is committed now
            tx_ack    <= ~cpha;
         end else begin
            if (sample_ev) begin
               rx_sh <= rx_next;
               if (bit_cnt == LAST_BIT) begin
                  data_in   <= rx_next;
                  word_sync <= 1'b1;
                  bit_cnt   <= '0;
                  wb        <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            if (shift_ev) begin
               if (wb) begin
                  tx_sh  <= data_out;
                  tx_ack <= 1'b1;
                  wb     <= 1'b0;
               end else begin
                  tx_sh <= tx_shifted;
               end
            end
         end
      end
   end

   assign miso = cs_eff ? 1'bz : tx_out;

endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: directed and randomised SPI frames against two slaves,
// an 8-bit MSB-first one and a 16-bit LSB-first one sharing sclk/mosi.
// Expected words, miso bits and strobe counts come from a frame-level model.
module tb_spi_slave_gen;

   logic        clk;
   logic        rst_n;
   logic        sclk;
   logic        cs8_n;
   logic        cs16_n;
   logic        mosi;
   logic        cpol;
   logic        cpha;
   wire         miso8;
   wire         miso16;
   logic        ws8;
   logic        ws16;
   logic        ack8;
   logic        ack16;
   logic        busy8;
   logic        busy16;
   logic [7:0]  din8;
   logic [7:0]  dout8;
   logic [15:0] din16;
   logic [15:0] dout16;
   logic        fe8;
   logic        fe16;

   int n_cmp;
   int n_fail;
   int ack_cnt;
   int fe_cnt;
   logic [31:0] got_q[$];
   logic [31:0] tx_mosi[0:3];
   logic [31:0] tx_miso[0:3];
   logic [31:0] last_rx[0:1];

   spi_slave_gen #(.WORD_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs8_n), .mosi(mosi),
      .miso(miso8), .cpol(cpol), .cpha(cpha), .word_sync(ws8),
      .data_in(din8), .data_out(dout8), .tx_ack(ack8), .busy(busy8)
`ifdef SPI_FRAME_ERR_EN
      , .frame_err(fe8)
`endif
   );

   spi_slave_gen #(.WORD_W(16), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs16_n), .mosi(mosi),
      .miso(miso16), .cpol(cpol), .cpha(cpha), .word_sync(ws16),
      .data_in(din16), .data_out(dout16), .tx_ack(ack16), .busy(busy16)
`ifdef SPI_FRAME_ERR_EN
      , .frame_err(fe16)
`endif
   );

`ifndef SPI_FRAME_ERR_EN
   assign fe8  = 1'b0;
   assign fe16 = 1'b0;
`endif

   // clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // strobe monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (ws8)  got_q.push_back(32'(din8));
      if (ws16) got_q.push_back(32'(din16));
      ack_cnt = ack_cnt + int'(ack8) + int'(ack16);
      fe_cnt  = fe_cnt + int'(fe8) + int'(fe16);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   function automatic logic wbit(input logic [31:0] word, input int w, input bit msbf, input int b);
      return msbf ? word[w-1-b] : word[b];
   endfunction

   function automatic logic [31:0] din_of(input int sel);
      return (sel != 0) ? 32'(din16) : 32'(din8);
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel != 0) ? busy16 : busy8;
   endfunction

   function automatic logic miso_of(input int sel);
      return (sel != 0) ? miso16 : miso8;
   endfunction

   task automatic set_dout(input int sel, input logic [31:0] v);
      if (sel != 0) dout16 = v[15:0];
      else          dout8  = v[7:0];
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_word_sync8"}, 32'(ws8), 0);
      chk({tag, "_word_sync16"}, 32'(ws16), 0);
      chk({tag, "_tx_ack8"}, 32'(ack8), 0);
      chk({tag, "_tx_ack16"}, 32'(ack16), 0);
      chk({tag, "_busy8"}, 32'(busy8), 0);
      chk({tag, "_busy16"}, 32'(busy16), 0);
      chk({tag, "_data_in8"}, 32'(din8), 0);
      chk({tag, "_data_in16"}, 32'(din16), 0);
`ifdef SPI_FRAME_ERR_EN
      chk({tag, "_frame_err"}, 32'(fe8 | fe16), 0);
`endif
   endtask

   // One master frame of nbits bits; rst_at/flip_at < 0 disable those events.
   task automatic spi_frame(input int sel, input bit pol, input bit pha, input int nbits,
                            input int rst_at, input int flip_at);
      int  w;
      bit  msbf;
      int  nfull;
      int  nstart;
      int  k;
      int  b;
      bit  skip;
      logic exp_bit;
      w      = (sel != 0) ? 16 : 8;
      msbf   = (sel == 0);
      nfull  = nbits / w;
      nstart = (nbits + w - 1) / w;
      skip   = 1'b0;
      cpol   = pol;
      cpha   = pha;
      sclk   = pol;
      set_dout(sel, tx_miso[0]);
      half(); half();
      got_q.delete();
      ack_cnt = 0;
      fe_cnt  = 0;
      if (sel != 0) cs16_n = 1'b0;
      else          cs8_n  = 1'b0;
      half(); half();
      for (int j = 0; j < nbits; j++) begin
         k = j / w;
         b = j % w;
         if (j == rst_at) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check_reset_outputs("midreset");
            rst_n = 1'b1;
            skip  = 1'b1;
            last_rx[0] = '0;
            last_rx[1] = '0;
            got_q.delete();
            ack_cnt = 0;
            fe_cnt  = 0;
         end
         if (j == flip_at) cpha = ~pha;
         if (j == nbits / 2 && !skip) chk("busy_mid_frame", 32'(busy_of(sel)), 1);
         exp_bit = wbit(tx_miso[k], w, msbf, b);
         if (!pha) begin
            mosi = wbit(tx_mosi[k], w, msbf, b);
            half();
            if (!skip) chk($sformatf("miso_w%0d_b%0d", k, b), 32'(miso_of(sel)), 32'(exp_bit));
            sclk = ~sclk;
            half();
            sclk = ~sclk;
         end else begin
            half();
            sclk = ~sclk;
            mosi = wbit(tx_mosi[k], w, msbf, b);
            half();
            if (!skip) chk($sformatf("miso_w%0d_b%0d", k, b), 32'(miso_of(sel)), 32'(exp_bit));
            sclk = ~sclk;
         end
         if (b == 1 && k + 1 < nstart) set_dout(sel, tx_miso[k+1]);
      end
      half(); half();
      if (skip) chk("busy_after_reset", 32'(busy_of(sel)), 0);
      if (sel != 0) cs16_n = 1'b1;
      else          cs8_n  = 1'b1;
      repeat (12) @(negedge clk);
      if (!skip && nfull > 0) last_rx[sel] = tx_mosi[nfull-1];
      chk("word_count", 32'(got_q.size()), skip ? 0 : 32'(nfull));
      for (int i = 0; i < got_q.size() && i < nfull; i++)
         chk($sformatf("rx_word%0d", i), got_q[i], tx_mosi[i]);
      chk("data_in", din_of(sel), last_rx[sel]);
      chk("tx_ack_count", 32'(ack_cnt), skip ? 0 : (pha ? 32'(nstart) : 32'(nfull + 1)));
`ifdef SPI_FRAME_ERR_EN
      chk("frame_err_count", 32'(fe_cnt), (!skip && (nbits % w) != 0) ? 1 : 0);
`endif
      chk("busy_idle", 32'(busy_of(sel)), 0);
   endtask

   task automatic fill_random(input int sel);
      logic [31:0] mask;
      mask = (sel != 0) ? 32'h0000_FFFF : 32'h0000_00FF;
      for (int i = 0; i < 4; i++) begin
         tx_mosi[i] = $urandom() & mask;
         tx_miso[i] = $urandom() & mask;
      end
   endtask

   // directed steps followed by randomised frames
   initial begin
      int sel;
      int nbits;
      int w;
      n_cmp = 0;
      n_fail = 0;
      ack_cnt = 0;
      fe_cnt = 0;
      rst_n = 1'b0;
      sclk = 1'b0;
      cs8_n = 1'b1;
      cs16_n = 1'b1;
      mosi = 1'b0;
      cpol = 1'b0;
      cpha = 1'b0;
      dout8 = '0;
      dout16 = '0;
      last_rx[0] = '0;
      last_rx[1] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_busy8", 32'(busy8), 0);

      // mode 0, single word A5 in, 3C out
      fill_random(0);
      tx_mosi[0] = 32'hA5;
      tx_miso[0] = 32'h3C;
      spi_frame(0, 1'b0, 1'b0, 8, -1, -1);

      // mode 3, two back-to-back words, data_out changed after the first tx_ack
      fill_random(0);
      tx_mosi[0] = 32'h12; tx_mosi[1] = 32'h34;
      tx_miso[0] = 32'h96; tx_miso[1] = 32'hC3;
      spi_frame(0, 1'b1, 1'b1, 16, -1, -1);

      // mode 1, 16-bit LSB-first
      fill_random(1);
      tx_mosi[0] = 32'h8001;
      spi_frame(1, 1'b0, 1'b1, 16, -1, -1);

      // mode 0 truncated after 5 bits, then a full frame
      fill_random(0);
      spi_frame(0, 1'b0, 1'b0, 5, -1, -1);
      fill_random(0);
      spi_frame(0, 1'b0, 1'b0, 8, -1, -1);

      // mode 2 frame cut by reset after 3 bits, then a clean 5A frame
      fill_random(0);
      spi_frame(0, 1'b1, 1'b0, 8, 3, -1);
      fill_random(0);
      tx_mosi[0] = 32'h5A;
      spi_frame(0, 1'b1, 1'b0, 8, -1, -1);

      // cpha pin toggled mid-frame must not change the latched mode
      fill_random(0);
      spi_frame(0, 1'b0, 1'b0, 8, -1, 4);

      // randomised frames across modes, widths and truncation
      for (int r = 0; r < 14; r++) begin
         sel = int'($urandom_range(0, 1));
         w = (sel != 0) ? 16 : 8;
         fill_random(sel);
         nbits = w * int'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) nbits = nbits - int'($urandom_range(1, w - 1));
         spi_frame(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nbits, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
